// File: rtl/memory_router.sv
// Address decoder and sequencer between the CPU bus arbiter and the four memory targets.
// Each accepted request goes to exactly one target and returns a one-cycle bus_done pulse.
//
// state      | meaning
// IDLE       | waiting for bus_start; decodes and launches the access
// SDRAM_WAIT | SDRAM access in flight, waiting for sdram_done or timeout
// FLASH_WAIT | flash read in flight, waiting for flash_done or timeout
// IO_WAIT    | I/O access in flight, waiting for io_done or timeout
// ROM_WAIT   | rom_addr applied, rom_q is captured on the next edge
// FINISH     | bus_done (and bus_err) presented for one cycle
module memory_router #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic        bus_we,
    input  logic        bus_start,
    output logic [31:0] bus_q,
    output logic        bus_done,
    output logic        bus_err,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_start,
    input  logic [31:0] sdram_q,
    input  logic        sdram_done,
    output logic [22:0] flash_addr,
    output logic        flash_start,
    input  logic [31:0] flash_q,
    input  logic        flash_done,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_q,
    output logic [7:0]  io_addr,
    output logic [31:0] io_data,
    output logic        io_we,
    output logic        io_start,
    input  logic [31:0] io_q,
    input  logic        io_done
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SDRAM_WAIT, FLASH_WAIT, IO_WAIT, ROM_WAIT, FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          hit_sdram, hit_flash, hit_io, hit_rom;
    logic          wait_timeout;
    logic          tgt_done;
    logic [31:0]   tgt_q;

    assign hit_sdram    = (bus_addr[26:23] == 4'h0);
    assign hit_flash    = (bus_addr[26:23] == 4'h1);
    assign hit_io       = (bus_addr[26:8]  == 19'h70000);
    assign hit_rom      = (bus_addr[26:10] == 17'h1E000);
    assign wait_timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Only the done/q of the target we are actually waiting on is visible; stray pulses drop here.
    always_comb begin
        tgt_done = 1'b0;
        tgt_q    = '0;
        case (state)
            SDRAM_WAIT: begin tgt_done = sdram_done; tgt_q = sdram_q; end
            FLASH_WAIT: begin tgt_done = flash_done; tgt_q = flash_q; end
            IO_WAIT:    begin tgt_done = io_done;    tgt_q = io_q;    end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus_q       <= '0;
            bus_done    <= 1'b0;
            bus_err     <= 1'b0;
            sdram_addr  <= '0;
            sdram_data  <= '0;
            sdram_we    <= 1'b0;
            sdram_start <= 1'b0;
            flash_addr  <= '0;
            flash_start <= 1'b0;
            rom_addr    <= '0;
            io_addr     <= '0;
            io_data     <= '0;
            io_we       <= 1'b0;
            io_start    <= 1'b0;
        end else begin
            sdram_start <= 1'b0;
            flash_start <= 1'b0;
            io_start    <= 1'b0;
            bus_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_start) begin
                        wait_cnt <= '0;
                        if (hit_sdram) begin
                            sdram_addr  <= bus_addr[22:0];
                            sdram_data  <= bus_data;
                            sdram_we    <= bus_we;
                            sdram_start <= 1'b1;
                            state       <= SDRAM_WAIT;
                        end else if (hit_flash && !bus_we) begin
                            flash_addr  <= bus_addr[22:0];
                            flash_start <= 1'b1;
                            state       <= FLASH_WAIT;
                        end else if (hit_io) begin
                            io_addr  <= bus_addr[7:0];
                            io_data  <= bus_data;
                            io_we    <= bus_we;
                            io_start <= 1'b1;
                            state    <= IO_WAIT;
                        end else if (hit_rom && !bus_we) begin
                            rom_addr <= bus_addr[9:0];
                            state    <= ROM_WAIT;
                        end else begin
                            bus_q    <= ERR_DATA;
                            bus_err  <= 1'b1;
                            bus_done <= 1'b1;
                            state    <= FINISH;
                        end
                    end
                end
                SDRAM_WAIT, FLASH_WAIT, IO_WAIT: begin
                    if (tgt_done) begin
                        bus_q    <= tgt_q;
                        bus_err  <= 1'b0;
                        bus_done <= 1'b1;
                        state    <= FINISH;
                    end else if (wait_timeout) begin
                        bus_q    <= ERR_DATA;
                        bus_err  <= 1'b1;
                        bus_done <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ROM_WAIT: begin
                    bus_q    <= rom_q;
                    bus_err  <= 1'b0;
                    bus_done <= 1'b1;
                    state    <= FINISH;
                end
                FINISH: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_router.sv
// Randomized bench for memory_router: responders for each target plus an address-map
// reference model that predicts target, data, error flag and latency of every access.
module tb_memory_router;

    localparam int TMO = 16;
    localparam int R_SDRAM = 0, R_FLASH = 1, R_IO = 2, R_ROM = 3, R_NONE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we, bus_start;
    logic [31:0] bus_q;
    logic        bus_done, bus_err;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_we, sdram_start;
    logic [31:0] sdram_q;
    logic        sdram_done;
    logic [22:0] flash_addr;
    logic        flash_start;
    logic [31:0] flash_q;
    logic        flash_done;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;
    logic [7:0]  io_addr;
    logic [31:0] io_data;
    logic        io_we, io_start;
    logic [31:0] io_q;
    logic        io_done;

    logic [31:0] rom_mem [1024];
    assign rom_q = rom_mem[rom_addr];

    memory_router #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
        .bus_q(bus_q), .bus_done(bus_done), .bus_err(bus_err),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_start(sdram_start), .sdram_q(sdram_q), .sdram_done(sdram_done),
        .flash_addr(flash_addr), .flash_start(flash_start), .flash_q(flash_q),
        .flash_done(flash_done),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .io_addr(io_addr), .io_data(io_data), .io_we(io_we), .io_start(io_start),
        .io_q(io_q), .io_done(io_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected contents of each target's held request registers
    logic [55:0] sh_sdram;
    logic [22:0] sh_flash;
    logic [40:0] sh_io;
    logic [9:0]  sh_rom;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int region_of(input logic [26:0] a);
        if (a < 27'h0800000) return R_SDRAM;
        if (a < 27'h1000000) return R_FLASH;
        if (a >= 27'h7000000 && a <= 27'h70000FF) return R_IO;
        if (a >= 27'h7800000 && a <= 27'h78003FF) return R_ROM;
        return R_NONE;
    endfunction

    // One bus access. With b2b set, the call starts in the FINISH cycle of the previous access.
    task automatic run_txn(input logic [26:0] a, input logic [31:0] wd, input logic we,
                           input int dly, input logic [31:0] tq, input bit b2b);
        int          reg_id, exp_lat, exp_starts, starts, start_c;
        bit          is_err, exp_err, seen;
        logic [31:0] exp_q;
        logic [2:0]  exp_which;
        reg_id = region_of(a);
        is_err = (reg_id == R_NONE) || (we && (reg_id == R_FLASH || reg_id == R_ROM));
        exp_err = is_err;
        exp_which = (reg_id == R_SDRAM) ? 3'b100 : (reg_id == R_FLASH) ? 3'b010 :
                    (reg_id == R_IO) ? 3'b001 : 3'b000;
        exp_starts = (is_err || reg_id == R_ROM) ? 0 : 1;
        if (is_err) begin
            exp_lat = 1; exp_q = 32'h0;
        end else if (reg_id == R_ROM) begin
            exp_lat = 2; exp_q = rom_mem[10'(a - 27'h7800000)];
        end else if (dly + 1 <= TMO) begin
            exp_lat = dly + 2; exp_q = tq;
        end else begin
            exp_lat = TMO + 1; exp_q = 32'h0; exp_err = 1'b1;
        end
        if (!is_err) begin
            case (reg_id)
                R_SDRAM: sh_sdram = {we, 23'(a), wd};
                R_FLASH: sh_flash = 23'(a - 27'h0800000);
                R_IO:    sh_io    = {we, 8'(a - 27'h7000000), wd};
                default: sh_rom   = 10'(a - 27'h7800000);
            endcase
        end

        if (!b2b) begin
            bus_start = 1'b0;
            @(posedge clk); #1;
        end
        bus_addr = a; bus_data = wd; bus_we = we; bus_start = 1'b1;
        if (b2b) begin
            @(posedge clk); #1;
            check_eq("b2b_done_drop", 64'(bus_done), 64'(0));
        end

        starts = 0; start_c = -1; seen = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 64 && !seen; c++) begin
            sdram_done = 1'b0; flash_done = 1'b0; io_done = 1'b0;
            sdram_q = ~tq; flash_q = ~tq; io_q = ~tq;
            if (sdram_start || flash_start || io_start) begin
                starts++;
                start_c = c;
                check_eq("start_target", 64'({sdram_start, flash_start, io_start}), 64'(exp_which));
                case (reg_id)
                    R_SDRAM: check_eq("sdram_req", 64'({sdram_we, sdram_addr, sdram_data}),
                                      64'({we, 23'(a), wd}));
                    R_FLASH: check_eq("flash_req", 64'(flash_addr), 64'(23'(a - 27'h0800000)));
                    R_IO:    check_eq("io_req", 64'({io_we, io_addr, io_data}),
                                      64'({we, 8'(a - 27'h7000000), wd}));
                    default: ;
                endcase
            end
            if (bus_done) begin
                seen = 1'b1;
                check_eq("latency", 64'(c + 1), 64'(exp_lat));
                check_eq("bus_q", 64'(bus_q), 64'(exp_q));
                check_eq("bus_err", 64'(bus_err), 64'(exp_err));
            end else begin
                if (start_c >= 0 && c == start_c + dly) begin
                    case (reg_id)
                        R_SDRAM: begin sdram_done = 1'b1; sdram_q = tq; end
                        R_FLASH: begin flash_done = 1'b1; flash_q = tq; end
                        R_IO:    begin io_done    = 1'b1; io_q    = tq; end
                        default: ;
                    endcase
                end
                @(posedge clk); #1;
            end
        end
        check_eq("done_seen", 64'(seen), 64'(1));
        check_eq("start_count", 64'(starts), 64'(exp_starts));
        check_eq("hold_sdram", 64'({sdram_we, sdram_addr, sdram_data}), 64'(sh_sdram));
        check_eq("hold_flash", 64'(flash_addr), 64'(sh_flash));
        check_eq("hold_io", 64'({io_we, io_addr, io_data}), 64'(sh_io));
        check_eq("hold_rom", 64'(rom_addr), 64'(sh_rom));
    endtask

    logic [26:0] edges [13];
    int          quiet;

    initial begin
        edges = '{27'h07FFFFF, 27'h0800000, 27'h0FFFFFF, 27'h1000000, 27'h6FFFFFF,
                  27'h7000000, 27'h70000FF, 27'h7000100, 27'h77FFFFF, 27'h7800000,
                  27'h78003FF, 27'h7800400, 27'h7FFFFFF};
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        rom_mem[5] = 32'h1234_5678;
        sh_sdram = '0; sh_flash = '0; sh_io = '0; sh_rom = '0;
        reset = 1'b0;
        bus_addr = '0; bus_data = '0; bus_we = 1'b0; bus_start = 1'b0;
        sdram_q = '0; sdram_done = 1'b0; flash_q = '0; flash_done = 1'b0;
        io_q = '0; io_done = 1'b0;

        #12;
        check_eq("reset_bus", 64'({bus_q, bus_done, bus_err}), 64'(0));
        check_eq("reset_start", 64'({sdram_start, flash_start, io_start}), 64'(0));
        check_eq("reset_addr", {sdram_addr, flash_addr, io_addr, rom_addr}, 64'(0));
        @(posedge clk); #3;
        reset = 1'b1;

        run_txn(27'h0000010, 32'h0, 1'b0, 2, 32'hCAFE_BABE, 1'b0);
        run_txn(27'h7800005, 32'h0, 1'b0, 1, 32'h0, 1'b0);
        bus_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("q_hold_idle", 64'(bus_q), 64'(32'h1234_5678));

        run_txn(27'h0800000, 32'h1111_2222, 1'b1, 1, 32'h0, 1'b0);
        run_txn(27'h7800000, 32'h3333_4444, 1'b1, 1, 32'h0, 1'b0);
        run_txn(27'h2000000, 32'h0, 1'b0, 1, 32'h0, 1'b0);

        run_txn(27'h7000010, 32'h0, 1'b0, 1000, 32'h0, 1'b0);
        bus_start = 1'b0;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            io_done = (c == 1);
            io_q = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            if (bus_done) quiet++;
        end
        io_done = 1'b0;
        check_eq("late_done_ignored", 64'(quiet), 64'(0));

        run_txn(27'h7000003, 32'h0000_00A5, 1'b1, 1, 32'h0, 1'b0);
        check_eq("io_write_regs", 64'({io_we, io_addr, io_data}), 64'({1'b1, 8'h03, 32'h0000_00A5}));
        run_txn(27'h0000040, 32'h0, 1'b0, 3, 32'h0BAD_F00D, 1'b1);

        // Asynchronous reset while an SDRAM access is outstanding
        run_txn(27'h0000123, 32'h0, 1'b0, 1, 32'h1357_9BDF, 1'b0);
        bus_start = 1'b0;
        @(posedge clk); #1;
        bus_addr = 27'h0000200; bus_we = 1'b1; bus_data = 32'h55; bus_start = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_pre_start", 64'(sdram_start), 64'(1));
        bus_start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_eq("rst_async_bus", 64'({bus_q, bus_done, bus_err}), 64'(0));
        check_eq("rst_async_tgt", 64'({sdram_start, flash_start, io_start, sdram_we, io_we}), 64'(0));
        check_eq("rst_async_addr", {sdram_addr, flash_addr, io_addr, rom_addr}, 64'(0));
        check_eq("rst_async_data", {sdram_data, io_data}, 64'(0));
        sh_sdram = '0; sh_flash = '0; sh_io = '0; sh_rom = '0;
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        sdram_done = 1'b1; sdram_q = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        sdram_done = 1'b0;
        quiet = 0;
        repeat (4) begin
            if (bus_done) quiet++;
            @(posedge clk); #1;
        end
        check_eq("rst_late_done", 64'(quiet), 64'(0));
        check_eq("rst_q_zero", 64'(bus_q), 64'(0));
        run_txn(27'h0000300, 32'h0, 1'b0, 2, 32'h2468_ACE0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int          k;
            logic [26:0] a;
            k = $urandom_range(0, 5);
            case (k)
                0: a = 27'($urandom_range(0, 32'h7FFFFF));
                1: a = 27'h0800000 + 27'($urandom_range(0, 32'h7FFFFF));
                2: a = 27'h7000000 + 27'($urandom_range(0, 255));
                3: a = 27'h7800000 + 27'($urandom_range(0, 1023));
                4: a = edges[$urandom_range(0, 12)];
                default: a = 27'($urandom);
            endcase
            run_txn(a, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                    $urandom, 1'($urandom_range(0, 1)));
        end
        bus_start = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
